// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag-vector layout for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHR  = 4'd2;
  localparam logic [3:0] OP_SHL  = 4'd3;
  localparam logic [3:0] OP_NAND = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_DIR  = 4'd6;
  localparam logic [3:0] OP_SAR  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StHold = 2'd2
  } alu_state_e;

  // Bit positions inside the packed {z, n, c, v} flag vector
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;
  localparam int unsigned NUM_FLAGS = 4;

endpackage

// File: rtl/alu_mul_serial.sv
// Iterative shift-add multiplier: one multiplier bit per clock, low WIDTH bits of the product.
// done_o is high during the last iteration cycle; prod_o is the value that iteration produces.
module alu_mul_serial #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] prod_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] step_acc;

  // Load operands on start, otherwise consume one multiplier bit while cnt is non-zero.
  always_comb begin
    step_acc = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start_i) begin
      cnt_d    = CntW'(WIDTH);
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - 1'b1;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = step_acc;
    end
  end

  // Iteration state; synchronous reset drops any in-flight product.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign done_o = (cnt_q == CntW'(1));
  assign prod_o = step_acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops register straight into the output stage, MUL runs on the
// serial multiplier. Output is held until the consumer takes it.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter bit          MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             v,
  output logic             err
);

  localparam int unsigned ShW = $clog2(WIDTH);

  alu_state_e           state_q, state_d;
  logic [WIDTH-1:0]     out_q, out_d;
  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic                 err_q, err_d;

  logic [WIDTH:0]       sum_ext, diff_ext;
  logic [WIDTH-1:0]     res;
  logic                 res_c, res_v, res_err;
  logic [NUM_FLAGS-1:0] res_flags;
  logic                 sh_big;
  logic [ShW-1:0]       sh_amt;
  logic                 is_mul, accept;
  logic                 mul_start, mul_done;
  logic [WIDTH-1:0]     mul_prod;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  // Shift amounts use all of b; anything >= WIDTH saturates
  assign sh_big   = (b >= WIDTH'(WIDTH));
  assign sh_amt   = b[ShW-1:0];

  // Single-cycle datapath: result plus carry/overflow/illegal for the presented opcode.
  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_v   = 1'b0;
    res_err = 1'b0;
    case (alu_op)
      OP_ADD: begin
        res   = sum_ext[WIDTH-1:0];
        res_c = sum_ext[WIDTH];
        res_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res   = diff_ext[WIDTH-1:0];
        res_c = diff_ext[WIDTH];
        res_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SHR:  res = sh_big ? '0 : (a >> sh_amt);
      OP_SHL:  res = sh_big ? '0 : (a << sh_amt);
      OP_NAND: res = ~(a & b);
      OP_OR:   res = a | b;
      OP_DIR:  res = a;
      OP_SAR:  res = sh_big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> sh_amt);
      // Legal MUL goes through the serial unit; this path only matters when it is disabled
      OP_MUL:  res_err = !MUL_EN;
      default: res_err = 1'b1;
    endcase
  end

  // Flags derived from the same result that gets registered; illegal ops report all-zero flags.
  always_comb begin
    res_flags         = '0;
    res_flags[FLAG_Z] = !res_err && (res == '0);
    res_flags[FLAG_N] = res[WIDTH-1];
    res_flags[FLAG_C] = res_c;
    res_flags[FLAG_V] = res_v;
  end

  assign is_mul    = MUL_EN && (alu_op == OP_MUL);
  assign in_ready  = !rst && ((state_q == StIdle) || ((state_q == StHold) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StHold);

  alu_mul_serial #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i  (clk),
    .rst_i  (rst),
    .start_i(mul_start),
    .a_i    (a),
    .b_i    (b),
    .done_o (mul_done),
    .prod_o (mul_prod)
  );

  // Next-state and output-register update; an accept overrides the HOLD->IDLE retire.
  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    flags_d   = flags_q;
    err_d     = err_q;
    mul_start = 1'b0;
    case (state_q)
      StIdle: ;
      StBusy: begin
        if (mul_done) begin
          out_d           = mul_prod;
          flags_d         = '0;
          flags_d[FLAG_Z] = (mul_prod == '0);
          flags_d[FLAG_N] = mul_prod[WIDTH-1];
          err_d           = 1'b0;
          state_d         = StHold;
        end
      end
      StHold: begin
        if (out_ready && !in_valid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (accept) begin
      if (is_mul) begin
        mul_start = 1'b1;
        state_d   = StBusy;
      end else begin
        out_d   = res;
        flags_d = res_flags;
        err_d   = res_err;
        state_d = StHold;
      end
    end
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      out_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign out = out_q;
  assign z   = flags_q[FLAG_Z];
  assign n   = flags_q[FLAG_N];
  assign c   = flags_q[FLAG_C];
  assign v   = flags_q[FLAG_V];
  assign err = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: WIDTH=16 with MUL, plus a MUL_EN=0 instance for the illegal-MUL case.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, in_valid, in_ready, out_valid, out_ready, z, n, c, v, err;
  logic [W-1:0] a, b, out;
  logic [3:0]   alu_op;
  logic         in_valid2, in_ready2, out_valid2, z2, n2, c2, v2, err2;
  logic [W-1:0] out2;

  int n_tests = 0;
  int n_fail  = 0;

  alu_seq #(
    .WIDTH (W),
    .MUL_EN(1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .alu_op   (alu_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .z        (z),
    .n        (n),
    .c        (c),
    .v        (v),
    .err      (err)
  );

  alu_seq #(
    .WIDTH (W),
    .MUL_EN(1'b0)
  ) dut_nomul (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .a        (a),
    .b        (b),
    .alu_op   (alu_op),
    .out_valid(out_valid2),
    .out_ready(1'b1),
    .out      (out2),
    .z        (z2),
    .n        (n2),
    .c        (c2),
    .v        (v2),
    .err      (err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op for exactly one edge; caller guarantees in_ready at that edge
  task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    alu_op   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [W-1:0] exp_out,
                         input logic [3:0] exp_flags, input logic exp_err);
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_out"}, 32'(out), 32'(exp_out));
    chk({tag, "_zncv"}, 32'({z, n, c, v}), 32'(exp_flags));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  // MUL: out_valid must stay low for 15 edges after accept and rise on the 16th
  task automatic mul_check(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [W-1:0] exp_out, input logic [3:0] exp_flags);
    issue(OP_MUL, x, y);
    chk({tag, "_rdy0"}, 32'(in_ready), 32'd0);
    for (int i = 1; i < 16; i++) begin
      step();
      chk({tag, "_busy_vld"}, 32'(out_valid), 32'd0);
      chk({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
    end
    step();
    chk_res(tag, exp_out, exp_flags, 1'b0);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_valid2 = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    alu_op    = OP_ADD;
    step();
    step();

    // Reset state
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_zncv", 32'({z, n, c, v}), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_vld2", 32'(out_valid2), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_rdy", 32'(in_ready), 32'd1);
    chk("idle_rdy2", 32'(in_ready2), 32'd1);

    // Arithmetic and flags ({z,n,c,v})
    issue(OP_ADD, 16'hFFFF, 16'h0001);  chk_res("add_wrap", 16'h0000, 4'b1010, 1'b0);
    issue(OP_ADD, 16'h7FFF, 16'h0001);  chk_res("add_ovf", 16'h8000, 4'b0101, 1'b0);
    issue(OP_SUB, 16'h0003, 16'h0005);  chk_res("sub_brw", 16'hFFFE, 4'b0110, 1'b0);
    issue(OP_SUB, 16'h8000, 16'h0001);  chk_res("sub_ovf", 16'h7FFF, 4'b0001, 1'b0);
    issue(OP_SAR, 16'h8010, 16'h0004);  chk_res("sar4", 16'hF801, 4'b0100, 1'b0);
    issue(OP_SAR, 16'h8000, 16'h0014);  chk_res("sar_big", 16'hFFFF, 4'b0100, 1'b0);
    issue(OP_SHL, 16'h0001, 16'h0010);  chk_res("shl16", 16'h0000, 4'b1000, 1'b0);
    issue(OP_SHR, 16'hF000, 16'h0004);  chk_res("shr4", 16'h0F00, 4'b0000, 1'b0);
    issue(OP_NAND, 16'hFFFF, 16'hFFFF); chk_res("nand", 16'h0000, 4'b1000, 1'b0);
    issue(OP_OR, 16'h00F0, 16'h0F00);   chk_res("or", 16'h0FF0, 4'b0000, 1'b0);
    issue(OP_DIR, 16'h8001, 16'h1234);  chk_res("dir", 16'h8001, 4'b0100, 1'b0);
    step();
    chk("retire_idle", 32'(out_valid), 32'd0);

    // Serial multiply
    mul_check("mul", 16'h0123, 16'h0010, 16'h1230, 4'b0000);
    mul_check("mul_ff", 16'hFFFF, 16'hFFFF, 16'h0001, 4'b0000);
    step();
    chk("mul_retire", 32'(out_valid), 32'd0);

    // Back-pressure: result held, next op waits
    issue(OP_ADD, 16'h1234, 16'h1111);
    out_ready = 1'b0;
    alu_op    = OP_SUB;
    a         = 16'h0010;
    b         = 16'h0001;
    in_valid  = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rdy", 32'(in_ready), 32'd0);
      chk("bp_vld", 32'(out_valid), 32'd1);
      chk("bp_out", 32'(out), 32'h2345);
      chk("bp_zncv", 32'({z, n, c, v}), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk_res("bp_next", 16'h000F, 4'b0000, 1'b0);

    // Streaming: one ADD result per cycle
    in_valid = 1'b1;
    alu_op   = OP_ADD;
    for (int i = 0; i < 8; i++) begin
      a = 16'(i << 8);
      b = 16'(i + 1);
      step();
      chk("stream_vld", 32'(out_valid), 32'd1);
      chk("stream_out", 32'(out), 32'((i << 8) + i + 1));
    end
    in_valid = 1'b0;
    step();

    // Reset in the middle of a MUL
    issue(OP_MUL, 16'h0005, 16'h0007);
    repeat (6) step();
    rst = 1'b1;
    step();
    chk("midrst_vld", 32'(out_valid), 32'd0);
    chk("midrst_out", 32'(out), 32'd0);
    chk("midrst_zncv", 32'({z, n, c, v}), 32'd0);
    chk("midrst_rdy", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_idle_rdy", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (20) begin
      step();
      if (out_valid) seen++;
    end
    chk("midrst_no_stale", 32'(seen), 32'd0);
    issue(OP_ADD, 16'h0002, 16'h0003);  chk_res("post_rst_add", 16'h0005, 4'b0000, 1'b0);

    // Illegal opcodes
    issue(4'hC, 16'h1234, 16'h5678);    chk_res("illegal_c", 16'h0000, 4'b0000, 1'b1);
    issue(4'hF, 16'h0000, 16'h0000);    chk_res("illegal_f", 16'h0000, 4'b0000, 1'b1);
    issue(OP_ADD, 16'h0001, 16'h0001);  chk_res("err_clear", 16'h0002, 4'b0000, 1'b0);
    step();

    // MUL with MUL_EN=0: illegal, single-cycle
    alu_op    = OP_MUL;
    a         = 16'h0003;
    b         = 16'h0003;
    in_valid2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    chk("nomul_vld", 32'(out_valid2), 32'd1);
    chk("nomul_err", 32'(err2), 32'd1);
    chk("nomul_out", 32'(out2), 32'd0);
    chk("nomul_zncv", 32'({z2, n2, c2, v2}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
